// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the single GPR write port between the pipeline writeback (priority)
// and a small FIFO of long-latency results, tracking outstanding results in a scoreboard.
module gpr_wb_arbiter #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p_wr,
   input  logic [4:0]  p_waddr,
   input  logic [31:0] p_wd,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic [4:0]  m_waddr,
   input  logic [31:0] m_wd,
   input  logic        alloc_en,
   input  logic [4:0]  alloc_addr,
   input  logic [4:0]  chk_addr0,
   input  logic [4:0]  chk_addr1,
   output logic        chk_busy,
   output logic        stall_req,
   output logic        gpr_wr,
   output logic [4:0]  gpr_waddr,
   output logic [31:0] gpr_wd,
   output logic [31:0] pend_mask
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    fifo_addr_q [FIFO_DEPTH];
   logic [4:0]    fifo_addr_d [FIFO_DEPTH];
   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [31:0]   fifo_data_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic          stall_req_q, stall_req_d;
   logic          gpr_wr_q, gpr_wr_d;
   logic [4:0]    gpr_waddr_q, gpr_waddr_d;
   logic [31:0]   gpr_wd_q, gpr_wd_d;
   logic          clr_pend_q, clr_pend_d;
   logic [4:0]    clr_addr_q, clr_addr_d;
   logic [31:0]   pend_mask_q, pend_mask_d;

   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic [4:0]    head_addr;
   logic [31:0]   head_data;

   assign m_ready    = (count_q != CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = m_valid && m_ready;
   assign pop        = !p_wr && !fifo_empty;
   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign head_data  = fifo_data_q[rd_ptr_q];

   assign chk_busy  = ((chk_addr0 != 5'd0) && pend_mask_q[chk_addr0]) ||
                      ((chk_addr1 != 5'd0) && pend_mask_q[chk_addr1]);
   assign stall_req = stall_req_q;
   assign gpr_wr    = gpr_wr_q;
   assign gpr_waddr = gpr_waddr_q;
   assign gpr_wd    = gpr_wd_q;
   assign pend_mask = pend_mask_q;

   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) begin
         fifo_addr_d[wr_ptr_q] = m_waddr;
         fifo_data_d[wr_ptr_q] = m_wd;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pipeline always wins; the buffered result only drains on otherwise idle cycles.
   always_comb begin
      gpr_wr_d    = 1'b0;
      gpr_waddr_d = gpr_waddr_q;
      gpr_wd_d    = gpr_wd_q;
      clr_pend_d  = 1'b0;
      clr_addr_d  = clr_addr_q;
      if (p_wr) begin
         gpr_wr_d    = 1'b1;
         gpr_waddr_d = p_waddr;
         gpr_wd_d    = p_wd;
      end else if (pop) begin
         gpr_wr_d    = 1'b1;
         gpr_waddr_d = head_addr;
         gpr_wd_d    = head_data;
         clr_pend_d  = 1'b1;
         clr_addr_d  = head_addr;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (pop || fifo_empty) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < SW'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
      stall_req_d = (starve_cnt_d >= SW'(STARVE_LIMIT));
   end

   // The clear lands together with the register-file commit; a same-edge allocate wins.
   always_comb begin
      pend_mask_d = pend_mask_q;
      if (clr_pend_q) begin
         pend_mask_d[clr_addr_q] = 1'b0;
      end
      if (alloc_en && (alloc_addr != 5'd0)) begin
         pend_mask_d[alloc_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_cnt_q <= '0;
         stall_req_q  <= 1'b0;
         gpr_wr_q     <= 1'b0;
         gpr_waddr_q  <= '0;
         gpr_wd_q     <= '0;
         clr_pend_q   <= 1'b0;
         clr_addr_q   <= '0;
         pend_mask_q  <= '0;
      end else begin
         fifo_addr_q  <= fifo_addr_d;
         fifo_data_q  <= fifo_data_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_cnt_q <= starve_cnt_d;
         stall_req_q  <= stall_req_d;
         gpr_wr_q     <= gpr_wr_d;
         gpr_waddr_q  <= gpr_waddr_d;
         gpr_wd_q     <= gpr_wd_d;
         clr_pend_q   <= clr_pend_d;
         clr_addr_q   <= clr_addr_d;
         pend_mask_q  <= pend_mask_d;
      end
   end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_gpr_wb_arbiter;

   localparam int FD  = 2;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p_wr = 1'b0;
   logic [4:0]  p_waddr = '0;
   logic [31:0] p_wd = '0;
   logic        m_valid = 1'b0;
   logic        m_ready;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wd = '0;
   logic        alloc_en = 1'b0;
   logic [4:0]  alloc_addr = '0;
   logic [4:0]  chk_addr0 = '0;
   logic [4:0]  chk_addr1 = '0;
   logic        chk_busy;
   logic        stall_req;
   logic        gpr_wr;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wd;
   logic [31:0] pend_mask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gpr_wb_arbiter #(.FIFO_DEPTH(FD), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .p_wr(p_wr), .p_waddr(p_waddr), .p_wd(p_wd),
      .m_valid(m_valid), .m_ready(m_ready), .m_waddr(m_waddr), .m_wd(m_wd),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_busy(chk_busy),
      .stall_req(stall_req), .gpr_wr(gpr_wr), .gpr_waddr(gpr_waddr),
      .gpr_wd(gpr_wd), .pend_mask(pend_mask)
   );

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] md_pend;
   logic        md_clr;
   logic [4:0]  md_clr_a;
   int          md_starve;
   logic        md_stall;
   logic        md_gwr;
   logic [4:0]  md_gwa;
   logic [31:0] md_gwd;

   task automatic model_reset();
      mq.delete();
      md_pend = '0; md_clr = 1'b0; md_clr_a = '0; md_starve = 0;
      md_stall = 1'b0; md_gwr = 1'b0; md_gwa = '0; md_gwd = '0;
   endtask

   // One clock edge of the specified behaviour, using the inputs as sampled at that edge.
   task automatic model_tick();
      bit   do_push;
      ent_t head;
      do_push = m_valid && (mq.size() != FD);
      if (md_clr) md_pend[md_clr_a] = 1'b0;
      if (alloc_en && alloc_addr != 5'd0) md_pend[alloc_addr] = 1'b1;
      md_clr = 1'b0;
      if (p_wr) begin
         md_gwr = 1'b1; md_gwa = p_waddr; md_gwd = p_wd;
         if (mq.size() > 0) begin
            if (md_starve < LIM) md_starve++;
         end else begin
            md_starve = 0;
         end
      end else if (mq.size() > 0) begin
         head = mq.pop_front();
         md_gwr = 1'b1; md_gwa = head.a; md_gwd = head.d;
         md_clr = 1'b1; md_clr_a = head.a;
         md_starve = 0;
      end else begin
         md_gwr = 1'b0;
         md_starve = 0;
      end
      md_stall = (md_starve >= LIM);
      if (do_push) mq.push_back(ent_t'{a: m_waddr, d: m_wd});
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic idle_inputs();
      p_wr = 1'b0; p_waddr = '0; p_wd = '0;
      m_valid = 1'b0; m_waddr = '0; m_wd = '0;
      alloc_en = 1'b0; alloc_addr = '0;
      chk_addr0 = '0; chk_addr1 = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (gpr_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_gpr_wr: got %0b want 0", gpr_wr); end
      checks++; if (gpr_waddr !== 5'd0) begin errors++; $display("[TB] FAIL reset_gpr_waddr: got %0d want 0", gpr_waddr); end
      checks++; if (gpr_wd !== 32'd0) begin errors++; $display("[TB] FAIL reset_gpr_wd: got %h want 0", gpr_wd); end
      checks++; if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b want 0", stall_req); end
      checks++; if (pend_mask !== 32'd0) begin errors++; $display("[TB] FAIL reset_pend: got %h want 0", pend_mask); end
      checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_m_ready: got %0b want 1", m_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_m_only();
      alloc_en = 1'b1; alloc_addr = 5'd5;
      tick();
      alloc_en = 1'b0;
      checks++; if (pend_mask !== 32'h0000_0020) begin errors++; $display("[TB] FAIL monly_alloc: got %h want 00000020", pend_mask); end
      m_valid = 1'b1; m_waddr = 5'd5; m_wd = 32'hDEAD_BEEF; chk_addr0 = 5'd5;
      #1;
      checks++; if (chk_busy !== 1'b1) begin errors++; $display("[TB] FAIL monly_busy0: got %0b want 1", chk_busy); end
      tick();
      m_valid = 1'b0;
      checks++; if (gpr_wr !== 1'b0) begin errors++; $display("[TB] FAIL monly_nowr: got %0b want 0", gpr_wr); end
      tick();
      checks++; if (gpr_wr !== 1'b1 || gpr_waddr !== 5'd5 || gpr_wd !== 32'hDEAD_BEEF) begin
         errors++; $display("[TB] FAIL monly_write: got wr=%0b a=%0d d=%h want wr=1 a=5 d=deadbeef", gpr_wr, gpr_waddr, gpr_wd);
      end
      checks++; if (chk_busy !== 1'b1) begin errors++; $display("[TB] FAIL monly_busy1: got %0b want 1", chk_busy); end
      tick();
      checks++; if (pend_mask !== 32'd0 || chk_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL monly_clear: got pend=%h busy=%0b want pend=0 busy=0", pend_mask, chk_busy);
      end
      checks++; if (gpr_wr !== 1'b0) begin errors++; $display("[TB] FAIL monly_idle: got %0b want 0", gpr_wr); end
      idle_inputs();
   endtask

   task automatic test_priority();
      m_valid = 1'b1; m_waddr = 5'd7; m_wd = 32'h22;
      tick();
      m_valid = 1'b0;
      p_wr = 1'b1; p_waddr = 5'd3; p_wd = 32'h11;
      tick();
      p_wr = 1'b0;
      checks++; if (gpr_wr !== 1'b1 || gpr_waddr !== 5'd3 || gpr_wd !== 32'h11) begin
         errors++; $display("[TB] FAIL prio_p_first: got wr=%0b a=%0d d=%h want wr=1 a=3 d=11", gpr_wr, gpr_waddr, gpr_wd);
      end
      tick();
      checks++; if (gpr_wr !== 1'b1 || gpr_waddr !== 5'd7 || gpr_wd !== 32'h22) begin
         errors++; $display("[TB] FAIL prio_m_next: got wr=%0b a=%0d d=%h want wr=1 a=7 d=22", gpr_wr, gpr_waddr, gpr_wd);
      end
      tick();
      checks++; if (gpr_wr !== 1'b0 || gpr_waddr !== 5'd7 || gpr_wd !== 32'h22) begin
         errors++; $display("[TB] FAIL prio_hold: got wr=%0b a=%0d d=%h want wr=0 a=7 d=22", gpr_wr, gpr_waddr, gpr_wd);
      end
   endtask

   task automatic test_starvation();
      m_valid = 1'b1; m_waddr = 5'd12; m_wd = 32'h5555;
      tick();
      m_valid = 1'b0;
      p_wr = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         p_waddr = 5'(k); p_wd = 32'(k * 100);
         tick();
         checks++; if (stall_req !== (k >= LIM) || gpr_waddr !== 5'(k)) begin
            errors++; $display("[TB] FAIL starve_%0d: got stall=%0b a=%0d want stall=%0b a=%0d", k, stall_req, gpr_waddr, (k >= LIM), k);
         end
      end
      p_wr = 1'b0;
      tick();
      checks++; if (stall_req !== 1'b0 || gpr_wr !== 1'b1 || gpr_waddr !== 5'd12 || gpr_wd !== 32'h5555) begin
         errors++; $display("[TB] FAIL starve_release: got stall=%0b wr=%0b a=%0d d=%h want stall=0 wr=1 a=12 d=5555", stall_req, gpr_wr, gpr_waddr, gpr_wd);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_full();
      p_wr = 1'b1; p_waddr = 5'd1; p_wd = 32'h1;
      m_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         m_waddr = 5'(20 + k); m_wd = 32'hA1 + 32'(k);
         #1;
         checks++; if (m_ready !== (k < FD)) begin
            errors++; $display("[TB] FAIL full_ready_%0d: got %0b want %0b", k, m_ready, (k < FD));
         end
         tick();
      end
      m_valid = 1'b0; p_wr = 1'b0;
      checks++; if (m_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_pop: got %0b want 0", m_ready); end
      tick();
      checks++; if (m_ready !== 1'b1 || gpr_waddr !== 5'd20 || gpr_wd !== 32'hA1) begin
         errors++; $display("[TB] FAIL full_pop1: got rdy=%0b a=%0d d=%h want rdy=1 a=20 d=a1", m_ready, gpr_waddr, gpr_wd);
      end
      tick();
      checks++; if (gpr_wr !== 1'b1 || gpr_waddr !== 5'd21 || gpr_wd !== 32'hA2) begin
         errors++; $display("[TB] FAIL full_pop2: got wr=%0b a=%0d d=%h want wr=1 a=21 d=a2", gpr_wr, gpr_waddr, gpr_wd);
      end
      tick();
      checks++; if (gpr_wr !== 1'b0) begin errors++; $display("[TB] FAIL full_dropped: got wr=%0b a=%0d want wr=0", gpr_wr, gpr_waddr); end
      idle_inputs();
   endtask

   task automatic test_race();
      alloc_en = 1'b1; alloc_addr = 5'd9;
      m_valid = 1'b1; m_waddr = 5'd9; m_wd = 32'h99;
      tick();
      alloc_en = 1'b0; m_valid = 1'b0;
      tick();
      checks++; if (gpr_wr !== 1'b1 || gpr_waddr !== 5'd9) begin
         errors++; $display("[TB] FAIL race_write: got wr=%0b a=%0d want wr=1 a=9", gpr_wr, gpr_waddr);
      end
      alloc_en = 1'b1; alloc_addr = 5'd9;
      tick();
      checks++; if (pend_mask !== 32'h0000_0200) begin errors++; $display("[TB] FAIL race_set_wins: got %h want 00000200", pend_mask); end
      alloc_addr = 5'd0;
      tick();
      alloc_en = 1'b0;
      checks++; if (pend_mask !== 32'h0000_0200) begin errors++; $display("[TB] FAIL race_r0: got %h want 00000200", pend_mask); end
      chk_addr0 = 5'd0; chk_addr1 = 5'd0;
      #1;
      checks++; if (chk_busy !== 1'b0) begin errors++; $display("[TB] FAIL race_busy_r0: got %0b want 0", chk_busy); end
      chk_addr1 = 5'd9;
      #1;
      checks++; if (chk_busy !== 1'b1) begin errors++; $display("[TB] FAIL race_busy_r9: got %0b want 1", chk_busy); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      alloc_en = 1'b1; alloc_addr = 5'd5;
      p_wr = 1'b1; p_waddr = 5'd2; p_wd = 32'h77;
      m_valid = 1'b1; m_waddr = 5'd30; m_wd = 32'h300;
      tick();
      alloc_en = 1'b0; m_waddr = 5'd31; m_wd = 32'h310;
      tick();
      m_valid = 1'b0;
      #1;
      checks++; if (pend_mask !== 32'h0000_0220 || m_ready !== 1'b0 || gpr_wr !== 1'b1) begin
         errors++; $display("[TB] FAIL rstmid_setup: got pend=%h rdy=%0b wr=%0b want pend=00000220 rdy=0 wr=1", pend_mask, m_ready, gpr_wr);
      end
      rst_n = 1'b0;
      idle_inputs();
      #1;
      model_reset();
      checks++; if (pend_mask !== 32'd0 || m_ready !== 1'b1 || gpr_wr !== 1'b0 || gpr_waddr !== 5'd0 || gpr_wd !== 32'd0 || stall_req !== 1'b0) begin
         errors++; $display("[TB] FAIL rstmid_async: got pend=%h rdy=%0b wr=%0b a=%0d d=%h stall=%0b want all 0, rdy=1", pend_mask, m_ready, gpr_wr, gpr_waddr, gpr_wd, stall_req);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (gpr_wr !== 1'b0 || m_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_drained_%0d: got wr=%0b rdy=%0b want wr=0 rdy=1", k, gpr_wr, m_ready);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         p_wr       = ($urandom_range(0, 9) < 6);
         p_waddr    = 5'($urandom);
         p_wd       = $urandom;
         m_valid    = ($urandom_range(0, 1) == 1);
         m_waddr    = 5'($urandom);
         m_wd       = $urandom;
         alloc_en   = ($urandom_range(0, 9) < 3);
         alloc_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         chk_addr0  = 5'($urandom);
         chk_addr1  = 5'($urandom);
         #1;
         checks++; if (m_ready !== (mq.size() != FD) ||
                       chk_busy !== ((chk_addr0 != 0 && md_pend[chk_addr0]) || (chk_addr1 != 0 && md_pend[chk_addr1]))) begin
            errors++; $display("[TB] FAIL rand_comb_%0d: got rdy=%0b busy=%0b want rdy=%0b, pend=%h c0=%0d c1=%0d",
                               n, m_ready, chk_busy, (mq.size() != FD), md_pend, chk_addr0, chk_addr1);
         end
         tick();
         checks++; if (gpr_wr !== md_gwr || gpr_waddr !== md_gwa || gpr_wd !== md_gwd ||
                       stall_req !== md_stall || pend_mask !== md_pend) begin
            errors++; $display("[TB] FAIL rand_reg_%0d: got wr=%0b a=%0d d=%h stall=%0b pend=%h want wr=%0b a=%0d d=%h stall=%0b pend=%h",
                               n, gpr_wr, gpr_waddr, gpr_wd, stall_req, pend_mask, md_gwr, md_gwa, md_gwd, md_stall, md_pend);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_m_only();
      test_priority();
      test_starvation();
      test_full();
      test_race();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
